// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file.
// Holds default widths, the stack-pointer constants and the write-port
// resolution helper used by both the storage update and the read bypass.
package reg_file_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 5;
  localparam int unsigned N_RD_DEF    = 3;
  localparam int unsigned N_WR_DEF    = 2;
  localparam int unsigned SP_IDX_DEF  = 29;
  localparam int unsigned SP_INIT_DEF = 32'h400;
  localparam int unsigned RST_VAL_DEF = 0;

  // Upper bound on write ports handled by the resolver.
  localparam int unsigned N_WR_MAX = 16;
  localparam int unsigned PORT_W   = 4;

  typedef struct packed {
    logic              hit;
    logic [PORT_W-1:0] port;
  } wr_win_t;

  // Highest-indexed asserted bit wins; hit is clear when no port targets the index.
  function automatic wr_win_t resolve_wr(input logic [N_WR_MAX-1:0] hit_vec);
    wr_win_t r;
    r = '0;
    for (int w = 0; w < int'(N_WR_MAX); w++) begin
      if (hit_vec[w]) begin
        r.hit  = 1'b1;
        r.port = PORT_W'(w);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp.
// master: issue/datapath side driving reads, writes, issue and flush.
// slave : the register file, returning combinational rd_data / rd_busy.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned N_RD   = N_RD_DEF,
  parameter int unsigned N_WR   = N_WR_DEF
);

  logic                     en;
  logic [N_RD*ADDR_W-1:0]   rd_addr;
  logic [N_RD*DATA_W-1:0]   rd_data;
  logic [N_RD-1:0]          rd_busy;
  logic [N_WR-1:0]          wr_en;
  logic [N_WR*ADDR_W-1:0]   wr_addr;
  logic [N_WR*DATA_W-1:0]   wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     flush;

  modport master (
    output en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy
  );

  modport slave (
    input  en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking a pending producer.
// Ports: clk, rst_n (sync, active-low), en, flush, clr (per-index writeback
// clears), iss_en/iss_addr (issue sets), busy (registered busy vector).
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     flush,
  input  logic [(1<<ADDR_W)-1:0]   clr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [(1<<ADDR_W)-1:0]   busy
);

  logic [(1<<ADDR_W)-1:0] busy_q;
  logic [(1<<ADDR_W)-1:0] busy_d;

  // Flush beats writeback clear; issue is applied last so a new producer stays pending.
  always_comb begin
    busy_d = busy_q;
    if (en) begin
      if (flush) begin
        busy_d = '0;
      end else begin
        busy_d = busy_q & ~clr;
      end
      if (iss_en && (iss_addr != '0)) begin
        busy_d[iss_addr] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with prioritised writes, same-cycle write-to-read
// bypass and a busy-bit scoreboard for RAW hazard detection.
// Ports: clk, rst_n (sync, active-low), bus (reg_file_mp_if.slave):
//   en, rd_addr/rd_data/rd_busy (combinational reads), wr_en/wr_addr/wr_data,
//   iss_en/iss_addr, flush.
// Register 0 reads zero and is never busy; SP_IDX resets to SP_INIT.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned        DATA_W  = DATA_W_DEF,
  parameter int unsigned        ADDR_W  = ADDR_W_DEF,
  parameter int unsigned        N_RD    = N_RD_DEF,
  parameter int unsigned        N_WR    = N_WR_DEF,
  parameter logic [DATA_W-1:0]  RST_VAL = DATA_W'(RST_VAL_DEF),
  parameter int unsigned        SP_IDX  = SP_IDX_DEF,
  parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(SP_INIT_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_mp_if.slave bus
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [ADDR_W-1:0] ra [N_RD];
  logic [ADDR_W-1:0] wa [N_WR];
  logic [DATA_W-1:0] wd [N_WR];
  logic [N_WR-1:0]   eff;

  // Storage for indices 1..NREG-1; index 0 reads as zero.
  logic [DATA_W-1:0] regs [1:NREG-1];

  wr_win_t           st_win  [NREG];
  logic [DATA_W-1:0] st_data [NREG];
  logic [NREG-1:0]   wr_clr;
  logic [NREG-1:0]   busy;

  // Unpack bus slices and qualify write strobes.
  always_comb begin
    for (int k = 0; k < int'(N_RD); k++) begin
      ra[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
    end
    for (int w = 0; w < int'(N_WR); w++) begin
      wa[w]  = bus.wr_addr[w*ADDR_W +: ADDR_W];
      wd[w]  = bus.wr_data[w*DATA_W +: DATA_W];
      eff[w] = bus.en & bus.wr_en[w] & (wa[w] != '0);
    end
  end

  // Per-index write resolution; also drives scoreboard clears.
  always_comb begin
    logic [N_WR_MAX-1:0] hv;
    hv = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      hv = '0;
      for (int w = 0; w < int'(N_WR); w++) begin
        hv[w] = eff[w] && (wa[w] == ADDR_W'(i));
      end
      st_win[i]  = resolve_wr(hv);
      wr_clr[i]  = st_win[i].hit;
      st_data[i] = '0;
      for (int w = 0; w < int'(N_WR); w++) begin
        if (st_win[i].port == PORT_W'(w)) begin
          st_data[i] = wd[w];
        end
      end
    end
  end

  // Storage update; reset discards any same-cycle writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < int'(NREG); i++) begin
        regs[i] <= (i == int'(SP_IDX)) ? SP_INIT : RST_VAL;
      end
    end else begin
      for (int i = 1; i < int'(NREG); i++) begin
        if (st_win[i].hit) begin
          regs[i] <= st_data[i];
        end
      end
    end
  end

  // Combinational read ports with bypass; a value written this cycle is not busy.
  always_comb begin
    logic [N_WR_MAX-1:0] hv;
    wr_win_t             win;
    logic [DATA_W-1:0]   byp;
    logic [DATA_W-1:0]   stored;
    hv          = '0;
    win         = '0;
    byp         = '0;
    stored      = '0;
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int k = 0; k < int'(N_RD); k++) begin
      hv = '0;
      for (int w = 0; w < int'(N_WR); w++) begin
        hv[w] = eff[w] && (wa[w] == ra[k]);
      end
      win = resolve_wr(hv);
      byp = '0;
      for (int w = 0; w < int'(N_WR); w++) begin
        if (win.port == PORT_W'(w)) begin
          byp = wd[w];
        end
      end
      stored = (ra[k] == '0) ? '0 : regs[ra[k]];
      bus.rd_data[k*DATA_W +: DATA_W] = win.hit ? byp : stored;
      bus.rd_busy[k] = busy[ra[k]] & ~win.hit;
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .flush    (bus.flush),
    .clr      (wr_clr),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .busy     (busy)
  );

endmodule
